traffic_req_cond: RTL and testbench

Input-conditioning stage directly upstream of the two-road traffic-light controller. Synchronises and debounces the raw left/right vehicle detectors and the hazard switch, then latches each vehicle request until the controller shows green on that side. Drives the controller's `L`, `R`, `H` inputs and reads back its `TL`/`TR` lamp outputs to clear serviced requests.

---
 rtl/traffic_req_cond.sv | 97 +++++++++
 tb/tb_traffic_req_cond.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_req_cond.sv
// Input conditioning for the two-road traffic-light controller: synchronises and
// debounces the detectors and hazard switch, and latches vehicle requests until green.
module traffic_req_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int CW         = $clog2(DEB_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_l,
    input  logic       raw_r,
    input  logic       raw_hz,
    input  logic [2:0] TL,
    input  logic [2:0] TR,
    output logic       L,
    output logic       R,
    output logic       H
);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [2:0]    LAMP_GREEN = 3'b001;

    // Channel order in the packed vectors: bit 0 left, bit 1 right, bit 2 hazard.
    logic [2:0]    w_raw;
    logic [2:0]    r_s1;
    logic [2:0]    r_s2;
    logic [2:0]    r_deb;
    logic [CW-1:0] r_cnt [3];

    logic          r_req_l;
    logic          r_req_r;
    logic          r_h;
    logic          w_green_l;
    logic          w_green_r;

    assign w_raw     = {raw_hz, raw_r, raw_l};
    assign w_green_l = (TL == LAMP_GREEN);
    assign w_green_r = (TR == LAMP_GREEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // A new level must be seen DEB_CYCLES edges in a row; any return restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deb <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Green clears first, so a car waiting on an already-green side raises nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_l <= 1'b0;
            r_req_r <= 1'b0;
            r_h     <= 1'b0;
        end else begin
            if (w_green_l) begin
                r_req_l <= 1'b0;
            end else if (r_deb[0]) begin
                r_req_l <= 1'b1;
            end

            if (w_green_r) begin
                r_req_r <= 1'b0;
            end else if (r_deb[1]) begin
                r_req_r <= 1'b1;
            end

            r_h <= r_deb[2];
        end
    end

    assign L = r_req_l;
    assign R = r_req_r;
    assign H = r_h;

endmodule

// File: tb/tb_traffic_req_cond.sv
// Bench for traffic_req_cond: directed scenarios, a windowed behavioural model
// compared every cycle, and literal checkpoints that pin the model.
module tb_traffic_req_cond;

    localparam int         D     = 4;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] YEL   = 3'b010;
    localparam logic [2:0] GREEN = 3'b001;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rawL;
    logic       rawR;
    logic       rawHz;
    logic [2:0] tl;
    logic [2:0] tr;
    logic       outL;
    logic       outR;
    logic       outH;

    int totalChecks = 0;
    int badChecks   = 0;

    traffic_req_cond #(.DEB_CYCLES(D)) dut (
        .clk    (clk),
        .rst_n  (rstN),
        .raw_l  (rawL),
        .raw_r  (rawR),
        .raw_hz (rawHz),
        .TL     (tl),
        .TR     (tr),
        .L      (outL),
        .R      (outR),
        .H      (outH)
    );

    always #5 clk = ~clk;

    // Model: each raw input reaches the debouncer two edges late; the debounced level
    // flips once the last D observations all disagree with it.
    logic [1:0]   mDelay  [3];
    logic [D-1:0] mWindow [3];
    logic [2:0]   mDeb;
    logic         mL;
    logic         mR;
    logic         mH;
    logic         mValid = 1'b0;

    always @(posedge clk) begin
        logic [2:0] rawNow;
        logic       obs;
        rawNow = {rawHz, rawR, rawL};
        if (!rstN) begin
            for (int c = 0; c < 3; c++) begin
                mDelay[c]  = '0;
                mWindow[c] = '0;
            end
            mDeb   = '0;
            mL     = 1'b0;
            mR     = 1'b0;
            mH     = 1'b0;
            mValid = 1'b1;
        end else begin
            if (tl == GREEN)  mL = 1'b0;
            else if (mDeb[0]) mL = 1'b1;
            if (tr == GREEN)  mR = 1'b0;
            else if (mDeb[1]) mR = 1'b1;
            mH = mDeb[2];
            for (int c = 0; c < 3; c++) begin
                obs        = mDelay[c][1];
                mWindow[c] = {mWindow[c][D-2:0], obs};
                mDelay[c]  = {mDelay[c][0], rawNow[c]};
                if (mDeb[c] == 1'b0 && mWindow[c] == {D{1'b1}}) mDeb[c] = 1'b1;
                else if (mDeb[c] == 1'b1 && mWindow[c] == {D{1'b0}}) mDeb[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            totalChecks += 3;
            if (outL !== mL) begin
                badChecks++;
                $display("[TB] FAIL model_L t=%0t got=%b want=%b", $time, outL, mL);
            end
            if (outR !== mR) begin
                badChecks++;
                $display("[TB] FAIL model_R t=%0t got=%b want=%b", $time, outR, mR);
            end
            if (outH !== mH) begin
                badChecks++;
                $display("[TB] FAIL model_H t=%0t got=%b want=%b", $time, outH, mH);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic l, input logic r,
                                 input logic hz, input logic [2:0] lampL,
                                 input logic [2:0] lampR, input int cycles);
        rstN  = rst;
        rawL  = l;
        rawR  = r;
        rawHz = hz;
        tl    = lampL;
        tr    = lampR;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input logic expL, input logic expR, input logic expH,
                               input string name);
        totalChecks++;
        if ({outL, outR, outH} !== {expL, expR, expH}) begin
            badChecks++;
            $display("[TB] FAIL %s got LRH=%b%b%b want LRH=%b%b%b",
                     name, outL, outR, outH, expL, expR, expH);
        end
    endtask

    initial begin
        // Reset with every detector already active, then release.
        applyStimulus(0, 1, 1, 1, RED, RED, 3);
        checkOutput(0, 0, 0, "reset_hold");
        applyStimulus(1, 1, 1, 1, RED, RED, 6);
        checkOutput(0, 0, 0, "reset_release_edge5");
        applyStimulus(1, 1, 1, 1, RED, RED, 1);
        checkOutput(1, 1, 1, "reset_release_edge6");

        // Debounce of a clean level.
        applyStimulus(0, 0, 0, 0, RED, RED, 2);
        applyStimulus(1, 1, 0, 0, RED, RED, 6);
        checkOutput(0, 0, 0, "deb_l_edge5");
        applyStimulus(1, 1, 0, 0, RED, RED, 1);
        checkOutput(1, 0, 0, "deb_l_edge6");

        // Bouncing detector never qualifies.
        applyStimulus(0, 0, 0, 0, RED, RED, 2);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 1, 0, 0, RED, RED, 3);
            applyStimulus(1, 0, 0, 0, RED, RED, 1);
        end
        applyStimulus(1, 0, 0, 0, RED, RED, 10);
        checkOutput(0, 0, 0, "bounce_l");

        // Latch, hold through non-green lamps, clear on green.
        applyStimulus(0, 0, 0, 0, RED, RED, 2);
        applyStimulus(1, 0, 1, 0, RED, RED, 7);
        checkOutput(0, 1, 0, "latch_r_set");
        applyStimulus(1, 0, 0, 0, RED, RED, 8);
        checkOutput(0, 1, 0, "latch_r_after_leave");
        applyStimulus(1, 0, 0, 0, RED, YEL, 3);
        checkOutput(0, 1, 0, "latch_r_yellow");
        applyStimulus(1, 0, 0, 0, RED, 3'b011, 2);
        checkOutput(0, 1, 0, "latch_r_illegal");
        applyStimulus(1, 0, 0, 0, RED, GREEN, 1);
        checkOutput(0, 0, 0, "clear_r_green");
        applyStimulus(1, 0, 0, 0, RED, RED, 2);
        checkOutput(0, 0, 0, "clear_r_stays");

        // Green suppresses a request from a car already waiting.
        applyStimulus(0, 0, 0, 0, RED, RED, 2);
        applyStimulus(1, 1, 0, 0, GREEN, RED, 10);
        checkOutput(0, 0, 0, "prio_l_green");
        applyStimulus(1, 1, 0, 0, RED, RED, 1);
        checkOutput(1, 0, 0, "prio_l_red");

        // Hazard level rises and falls; L untouched.
        applyStimulus(1, 1, 0, 1, RED, RED, 6);
        checkOutput(1, 0, 0, "hz_rise_edge5");
        applyStimulus(1, 1, 0, 1, RED, RED, 1);
        checkOutput(1, 0, 1, "hz_rise_edge6");
        applyStimulus(1, 1, 0, 0, RED, RED, 6);
        checkOutput(1, 0, 1, "hz_fall_edge5");
        applyStimulus(1, 1, 0, 0, RED, RED, 1);
        checkOutput(1, 0, 0, "hz_fall_edge6");

        // Mid-operation reset discards pending requests.
        applyStimulus(1, 1, 1, 0, RED, RED, 7);
        checkOutput(1, 1, 0, "both_pending");
        applyStimulus(1, 0, 0, 0, RED, RED, 8);
        checkOutput(1, 1, 0, "both_held");
        applyStimulus(0, 0, 0, 0, RED, RED, 1);
        checkOutput(0, 0, 0, "mid_reset");
        applyStimulus(1, 0, 0, 0, RED, RED, 10);
        checkOutput(0, 0, 0, "mid_reset_after");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
